// File: rtl/data_sram_arbiter.sv
// data_sram_arbiter: two-requester arbiter for a single-port synchronous data SRAM.
// Pipeline (p0) has priority; aux (p1) wins once it has been denied STARVE_LIMIT cycles.
module data_sram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p0_req,
    input  logic [3:0]  p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    input  logic        p1_req,
    input  logic [3:0]  p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        data_sram_en,
    output logic [3:0]  data_sram_we,
    output logic [31:0] data_sram_addr,
    output logic [31:0] data_sram_wdata,
    input  logic [31:0] data_sram_rdata
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic       p1_win;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       resp_pending_q, resp_pending_d;
    logic       resp_owner_q, resp_owner_d;

    // A starved aux requester overrides the pipeline; with LIMIT=0 it always does.
    assign p1_win = p1_req && (!p0_req || starve_cnt_q >= LIMIT);
    assign p0_gnt = !reset && p0_req && !p1_win;
    assign p1_gnt = !reset && p1_win;

    always_comb begin
        data_sram_en    = p0_gnt || p1_gnt;
        data_sram_we    = p1_gnt ? p1_we    : p0_gnt ? p0_we    : 4'd0;
        data_sram_addr  = p1_gnt ? p1_addr  : p0_gnt ? p0_addr  : 32'd0;
        data_sram_wdata = p1_gnt ? p1_wdata : p0_gnt ? p0_wdata : 32'd0;
        starve_cnt_d    = (p1_req && !p1_gnt) ? ((starve_cnt_q >= LIMIT) ? LIMIT : starve_cnt_q + 4'd1) : 4'd0;
        resp_pending_d  = data_sram_en && (data_sram_we == 4'd0);
        resp_owner_d    = p1_gnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt_q   <= 4'd0;
            resp_pending_q <= 1'b0;
            resp_owner_q   <= 1'b0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            resp_pending_q <= resp_pending_d;
            resp_owner_q   <= resp_owner_d;
        end
    end

    assign p0_rvalid = resp_pending_q && !resp_owner_q;
    assign p1_rvalid = resp_pending_q && resp_owner_q;
    assign p0_rdata  = data_sram_rdata;
    assign p1_rdata  = data_sram_rdata;
endmodule

// File: tb/tb_data_sram_arbiter.sv
// tb_data_sram_arbiter: directed checks of the data SRAM arbiter against a behavioural SRAM.
module tb_data_sram_arbiter;
    logic        clk = 0;
    logic        reset;
    logic        p0_req, p1_req;
    logic [3:0]  p0_we, p1_we;
    logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_we;
    logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata;
    logic        z_p0_gnt, z_p0_rvalid, z_p1_gnt, z_p1_rvalid, z_en;
    logic [31:0] z_p0_rdata, z_p1_rdata, z_addr, z_wdata;
    logic [3:0]  z_we;
    logic [31:0] mem [0:255];
    int n_chk = 0, n_pass = 0;

    always #5 clk = ~clk;

    data_sram_arbiter dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata)
    );

    data_sram_arbiter #(.STARVE_LIMIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(z_p0_gnt), .p0_rvalid(z_p0_rvalid), .p0_rdata(z_p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(z_p1_gnt), .p1_rvalid(z_p1_rvalid), .p1_rdata(z_p1_rdata),
        .data_sram_en(z_en), .data_sram_we(z_we), .data_sram_addr(z_addr),
        .data_sram_wdata(z_wdata), .data_sram_rdata(data_sram_rdata)
    );

    // Synchronous SRAM: read-before-write, byte enables, word index from addr[9:2].
    always @(posedge clk) begin
        if (data_sram_en) begin
            data_sram_rdata <= mem[data_sram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (data_sram_we[b]) mem[data_sram_addr[9:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic drv(input logic r0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                       input logic r1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]          = 32'hA0A0_0000;
        mem[1]          = 32'hB1B1_0004;
        mem[32'h100>>2] = 32'hDEAD_BEEF;
        data_sram_rdata = 32'h0;
        reset = 1;
        drv(1, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h4, 32'h0);
        #2;
        chk("rst_p0_gnt", p0_gnt, 0);
        chk("rst_p1_gnt", p1_gnt, 0);
        chk("rst_en", data_sram_en, 0);
        chk("rst_we", data_sram_we, 0);
        chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
        chk("rst_lim0_gnt", {z_p0_gnt, z_p1_gnt}, 0);
        drv(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        #10 reset = 0;
        tick();
        // idle: outputs zero even with garbage on ignored inputs
        drv(0, 4'hF, 32'hFFFF_FFFF, 32'h5555_5555, 0, 4'hF, 32'hFFFF_FFFF, 32'h5555_5555);
        #1;
        chk("idle_en", data_sram_en, 0);
        chk("idle_we", data_sram_we, 0);
        chk("idle_addr", data_sram_addr, 0);
        chk("idle_wdata", data_sram_wdata, 0);
        tick();
        // single read
        drv(1, 4'h0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("rd_p0_gnt", p0_gnt, 1);
        chk("rd_p1_gnt", p1_gnt, 0);
        chk("rd_addr", data_sram_addr, 32'h100);
        tick();
        drv(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        chk("rd_p0_rvalid", p0_rvalid, 1);
        chk("rd_p0_rdata", p0_rdata, 32'hDEAD_BEEF);
        chk("rd_p1_rvalid", p1_rvalid, 0);
        tick();
        chk("rd_rvalid_once", p0_rvalid, 0);
        // contention, limit 4 (and limit 0 on the second instance)
        drv(1, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h4, 32'h0);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("ct_p0_gnt%0d", c), p0_gnt, (c != 4));
            chk($sformatf("ct_p1_gnt%0d", c), p1_gnt, (c == 4));
            chk($sformatf("ct_starve%0d", c), dut.starve_cnt_q, (c == 5) ? 0 : c);
            chk($sformatf("lim0_gnt%0d", c), {z_p1_gnt, z_p0_gnt}, 2'b10);
            if (c > 0) begin
                chk($sformatf("ct_p0_rv%0d", c), p0_rvalid, (c - 1 != 4));
                chk($sformatf("ct_p1_rv%0d", c), p1_rvalid, (c - 1 == 4));
                chk($sformatf("ct_rdata%0d", c), p0_rdata, (c - 1 == 4) ? 32'hB1B1_0004 : 32'hA0A0_0000);
            end
            tick();
        end
        drv(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        chk("ct_last_rv", {p1_rvalid, p0_rvalid}, 2'b01);
        tick();
        // p1 full write, then partial p0 write, then readback
        drv(0, 4'h0, 32'h0, 32'h0, 1, 4'hF, 32'h40, 32'h1234_5678);
        #1;
        chk("wr_p1_gnt", p1_gnt, 1);
        chk("wr_we", data_sram_we, 4'hF);
        chk("wr_addr", data_sram_addr, 32'h40);
        chk("wr_wdata", data_sram_wdata, 32'h1234_5678);
        tick();
        drv(1, 4'h3, 32'h40, 32'hAAAA_BBBB, 0, 4'h0, 32'h0, 32'h0);
        chk("wr_no_rv", {p0_rvalid, p1_rvalid}, 0);
        #1;
        chk("pw_p0_gnt", p0_gnt, 1);
        tick();
        drv(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h40, 32'h0);
        chk("pw_no_rv", {p0_rvalid, p1_rvalid}, 0);
        tick();
        drv(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        chk("wrb_p1_rv", p1_rvalid, 1);
        chk("wrb_p0_rv", p0_rvalid, 0);
        chk("wrb_rdata", p1_rdata, 32'h1234_BBBB);
        tick();
        // back-to-back p0 read then p1 read
        drv(1, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        tick();
        drv(0, 4'h0, 32'h0, 32'h0, 1, 4'h0, 32'h4, 32'h0);
        chk("b2b_rv1", {p1_rvalid, p0_rvalid}, 2'b01);
        chk("b2b_d1", p0_rdata, 32'hA0A0_0000);
        #1;
        chk("b2b_p1_gnt", p1_gnt, 1);
        tick();
        drv(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        chk("b2b_rv2", {p1_rvalid, p0_rvalid}, 2'b10);
        chk("b2b_d2", p1_rdata, 32'hB1B1_0004);
        tick();
        // reset in the middle of a granted read
        drv(1, 4'h0, 32'h100, 32'h0, 1, 4'h0, 32'h4, 32'h0);
        tick();
        #1;
        chk("mr_gnt", p0_gnt, 1);
        chk("mr_starve_pre", dut.starve_cnt_q, 1);
        #1 reset = 1;
        #1;
        chk("mr_starve", dut.starve_cnt_q, 0);
        chk("mr_gnts", {p0_gnt, p1_gnt}, 0);
        chk("mr_en", data_sram_en, 0);
        tick();
        chk("mr_rvalid", {p0_rvalid, p1_rvalid}, 0);
        drv(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        #2 reset = 0;
        // first edge after reset accepts a request
        drv(1, 4'h0, 32'h100, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        #1;
        chk("post_gnt", p0_gnt, 1);
        tick();
        drv(0, 4'h0, 32'h0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        chk("post_rv", p0_rvalid, 1);
        chk("post_rdata", p0_rdata, 32'hDEAD_BEEF);
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/data_sram_arbiter.md
DATA_SRAM_ARBITER -- requirements
Module: data_sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied aux-request cycles after which aux wins; legal range 0..15.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port p0_req, input, 1, pipeline (EX) access request.
REQ-005 SHALL have port p0_we, input, 4, pipeline byte write enables; 0 means read.
REQ-006 SHALL have ports p0_addr and p0_wdata, input, 32 each, pipeline address and store data.
REQ-007 SHALL have port p0_gnt, output, 1, pipeline request accepted this cycle.
REQ-008 SHALL have ports p0_rvalid (output, 1) and p0_rdata (output, 32), pipeline read response.
REQ-009 SHALL have ports p1_req, p1_we[3:0], p1_addr[31:0], p1_wdata[31:0], p1_gnt, p1_rvalid and p1_rdata[31:0], aux requester, same meanings as port 0.
REQ-010 SHALL have ports data_sram_en (output, 1), data_sram_we (output, 4), data_sram_addr (output, 32), data_sram_wdata (output, 32) and data_sram_rdata (input, 32), the single-port synchronous SRAM, with read data valid one cycle after en.

Function
REQ-011 SHALL compute grants combinationally in the request cycle; p0_gnt and p1_gnt are never both 1.
REQ-012 SHALL grant p0 when p0_req=1, unless p1_req=1 and starve_cnt>=STARVE_LIMIT, in which case it SHALL grant p1.
REQ-013 SHALL grant p1 when p1_req=1 and p0_req=0.
REQ-014 SHALL drive data_sram_en=1 iff either grant is 1, with data_sram_we/addr/wdata taken from the granted requester.
REQ-015 SHALL drive data_sram_we=0, addr=0 and wdata=0 when no grant is given.
REQ-016 SHALL keep a 4-bit starve_cnt: +1 per cycle with p1_req=1 and p1_gnt=0, saturating at STARVE_LIMIT; cleared on p1_gnt=1 or p1_req=0.
REQ-017 SHALL, with STARVE_LIMIT=0, give p1 priority on every cycle where both requesters are requesting.
REQ-018 SHALL register resp_pending (1 bit) and resp_owner (1 bit) on every cycle: resp_pending=1 iff a read (granted we==0) was granted; resp_owner=index of the granted requester.
REQ-019 SHALL assert pN_rvalid=1 in the cycle after a granted read, only for N=resp_owner, for exactly 1 cycle per read.
REQ-020 SHALL never assert rvalid for writes, including partial writes (we not 0).
REQ-021 SHALL drive p0_rdata and p1_rdata directly from data_sram_rdata at all times; rdata is meaningful only when rvalid=1.
REQ-022 SHALL support back-to-back grants every cycle with no bubble, and a new grant in the same cycle as a response.
REQ-023 SHALL treat requester inputs as don't-care when the corresponding req=0.

Reset
REQ-024 SHALL, while reset=1, force p0_gnt=p1_gnt=0, data_sram_en=0, data_sram_we=0, and p0_rvalid=p1_rvalid=0.
REQ-025 SHALL asynchronously clear starve_cnt, resp_pending and resp_owner to 0 on reset assertion.
REQ-026 SHALL drop a read granted in the cycle before reset asserts: no rvalid is produced after reset.
REQ-027 SHALL accept requests from the first rising clk edge after reset deasserts.

Verification
REQ-028 Single read: p0_req=1, we=0, addr=0x100, with SRAM[0x100]=0xDEADBEEF -> p0_gnt=1 in the same cycle, then p0_rvalid=1 and p0_rdata=0xDEADBEEF next cycle, with p1_rvalid=0.
REQ-029 Contention, STARVE_LIMIT=4: both requesters read continuously -> p0 granted in cycles 0-3, p1 granted in cycle 4, starve_cnt=0 in cycle 5, p0 granted again in cycle 5.
REQ-030 Writes: p1 writes we=0xF to addr=0x40 with wdata=0x12345678, with p0 idle -> data_sram_we=0xF and data_sram_addr=0x40 in the same cycle, no rvalid; a later p1 read of 0x40 returns 0x12345678.
REQ-031 Back-to-back: p0 read 0x0, then p1 read 0x4 in consecutive cycles -> p0_rvalid in cycle 1 and p1_rvalid in cycle 2, each carrying the correct data, with no overlap.
REQ-032 Reset mid-op: p0 read granted in cycle N, then reset asserted asynchronously before edge N+1 -> p0_rvalid=0, starve_cnt=0, and all grants 0 while reset=1.
REQ-033 STARVE_LIMIT=0: both requesters active -> p1_gnt=1 and p0_gnt=0 every cycle.
